// File: rtl/ctrl_pkg.sv
// Shared types, field encodings and select codes for the CR16-subset control unit.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_LOAD_RD,
        S_LOAD_WB,
        S_STORE,
        S_JUMP,
        S_BRANCH
    } state_t;

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_MEM    = 4'b0100;
    localparam logic [3:0] OP_BCOND  = 4'b1100;

    // ALU function codes: the ext field for R-type, the opcode for immediates
    localparam logic [3:0] FN_AND    = 4'b0001;
    localparam logic [3:0] FN_OR     = 4'b0010;
    localparam logic [3:0] FN_XOR    = 4'b0011;
    localparam logic [3:0] FN_ADD    = 4'b0101;
    localparam logic [3:0] FN_SUB    = 4'b1001;
    localparam logic [3:0] FN_CMP    = 4'b1011;
    localparam logic [3:0] FN_MOV    = 4'b1101;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [3:0] CC_EQ     = 4'b0000;
    localparam logic [3:0] CC_NE     = 4'b0001;
    localparam logic [3:0] CC_CS     = 4'b0010;
    localparam logic [3:0] CC_CC     = 4'b0011;
    localparam logic [3:0] CC_MI     = 4'b0110;
    localparam logic [3:0] CC_PL     = 4'b0111;
    localparam logic [3:0] CC_UC     = 4'b1110;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;

    localparam logic [1:0] WD_IMM    = 2'b00;
    localparam logic [1:0] WD_RSRC   = 2'b01;
    localparam logic [1:0] WD_MEM    = 2'b10;
    localparam logic [1:0] WD_ALU    = 2'b11;

    localparam logic [1:0] ALUB_RSRC = 2'b00;
    localparam logic [1:0] ALUB_IMM  = 2'b01;
    localparam logic [1:0] ALUB_ONE  = 2'b10;
    localparam logic [1:0] ALUB_ZERO = 2'b11;

    localparam logic ALUA_RDEST = 1'b0;
    localparam logic ALUA_PC    = 1'b1;
    localparam logic PC_RSRC    = 1'b0;
    localparam logic PC_ALU     = 1'b1;
    localparam logic MEM_RSRC   = 1'b0;
    localparam logic MEM_PC     = 1'b1;

    typedef struct packed {
        logic       irwrite;
        logic       pcen;
        logic       regwrite;
        logic       memwrite;
        logic       flag_we;
        logic       pc_s;
        logic       mem_s;
        logic [1:0] wd_s;
        logic       alua_s;
        logic [1:0] alub_s;
        logic [2:0] alucont;
        logic       signext_sign;
    } ctrl_out_t;

    // flags is {C,Z,N}; unlisted condition codes are never taken
    function automatic logic cond_true(input logic [3:0] cond, input logic [2:0] flags);
        logic c, z, n;
        {c, z, n} = flags;
        case (cond)
            CC_EQ:   return z;
            CC_NE:   return ~z;
            CC_CS:   return c;
            CC_CC:   return ~c;
            CC_MI:   return n;
            CC_PL:   return ~n;
            CC_UC:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Maps an ALU function code to its datapath controls; shared by register and immediate forms.
module alu_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] fn,
    input  logic       is_imm,
    output logic [2:0] alucont,
    output logic       flag_we,
    output logic       signext_sign,
    output logic [1:0] wd_s,
    output logic       regwrite,
    output logic       legal
);

    always_comb begin
        alucont      = ALU_ADD;
        flag_we      = 1'b0;
        signext_sign = 1'b0;
        wd_s         = WD_ALU;
        regwrite     = 1'b1;
        legal        = 1'b1;
        case (fn)
            FN_ADD: begin
                flag_we      = 1'b1;
                signext_sign = 1'b1;
            end
            FN_SUB: begin
                alucont      = ALU_SUB;
                flag_we      = 1'b1;
                signext_sign = 1'b1;
            end
            FN_CMP: begin
                alucont      = ALU_SUB;
                flag_we      = 1'b1;
                signext_sign = 1'b1;
                regwrite     = 1'b0;
            end
            FN_AND: alucont = ALU_AND;
            FN_OR:  alucont = ALU_OR;
            FN_XOR: alucont = ALU_XOR;
            FN_MOV: wd_s    = is_imm ? WD_IMM : WD_RSRC;
            default: begin
                regwrite = 1'b0;
                legal    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle fetch/decode/execute control unit for the CR16-subset CPU.
// Define CTRL_BRANCH_EN to enable the conditional BRANCH and JUMP paths.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr,
    input  logic [2:0]       flags,
    output logic             irwrite,
    output logic             pcen,
    output logic             regwrite,
    output logic             memwrite,
    output logic             flag_we,
    output logic             pc_s,
    output logic             mem_s,
    output logic [1:0]       wd_s,
    output logic             alua_s,
    output logic [1:0]       alub_s,
    output logic [2:0]       alucont,
    output logic             signext_sign
);

    state_t     state_q, state_d;
    ctrl_out_t  out_q, out_d, fetch_out, out_gated;

    logic [3:0] opcode, cond, ext, fn;
    logic       is_imm, take;
    logic [2:0] dec_alucont;
    logic [1:0] dec_wd_s;
    logic       dec_flag_we, dec_signext, dec_regwrite, dec_legal;
    logic       unused_bits;

    assign opcode = instr[15:12];
    assign cond   = instr[11:8];
    assign ext    = instr[7:4];
    assign is_imm = (opcode != OP_RTYPE);
    assign fn     = is_imm ? opcode : ext;

    alu_decode u_alu_decode (
        .fn           (fn),
        .is_imm       (is_imm),
        .alucont      (dec_alucont),
        .flag_we      (dec_flag_we),
        .signext_sign (dec_signext),
        .wd_s         (dec_wd_s),
        .regwrite     (dec_regwrite),
        .legal        (dec_legal)
    );

`ifdef CTRL_BRANCH_EN
    assign take        = cond_true(cond, flags);
    assign unused_bits = ^instr[3:0];
`else
    assign take        = 1'b0;
    assign unused_bits = ^{instr[3:0], flags};
`endif

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: if (dec_legal) state_d = S_EXEC_R;
                    OP_MEM: begin
                        case (ext)
                            EXT_LOAD:  state_d = S_LOAD_RD;
                            EXT_STOR:  state_d = S_STORE;
                            EXT_JCOND: if (take) state_d = S_JUMP;
                            default:   state_d = S_FETCH;
                        endcase
                    end
                    OP_BCOND: if (take) state_d = S_BRANCH;
                    default:  if (dec_legal) state_d = S_EXEC_I;
                endcase
            end
            S_LOAD_RD: state_d = S_LOAD_WB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs are registered against the state being entered, so they line up with it
    always_comb begin
        out_d = '0;
        case (state_d)
            S_FETCH: begin
                out_d.irwrite = 1'b1;
                out_d.mem_s   = MEM_PC;
            end
            S_DECODE: begin
                out_d.pcen    = 1'b1;
                out_d.pc_s    = PC_ALU;
                out_d.alua_s  = ALUA_PC;
                out_d.alub_s  = ALUB_ONE;
                out_d.alucont = ALU_ADD;
            end
            S_EXEC_R, S_EXEC_I: begin
                out_d.alua_s       = ALUA_RDEST;
                out_d.alub_s       = is_imm ? ALUB_IMM : ALUB_RSRC;
                out_d.wd_s         = dec_wd_s;
                out_d.regwrite     = dec_regwrite;
                out_d.flag_we      = dec_flag_we;
                out_d.alucont      = dec_alucont;
                out_d.signext_sign = is_imm & dec_signext;
            end
            S_LOAD_RD: out_d.mem_s = MEM_RSRC;
            S_LOAD_WB: begin
                out_d.wd_s     = WD_MEM;
                out_d.regwrite = 1'b1;
            end
            S_STORE: begin
                out_d.mem_s    = MEM_RSRC;
                out_d.memwrite = 1'b1;
            end
            S_JUMP: begin
                out_d.pc_s = PC_RSRC;
                out_d.pcen = 1'b1;
            end
            S_BRANCH: begin
                out_d.alua_s       = ALUA_PC;
                out_d.alub_s       = ALUB_IMM;
                out_d.signext_sign = 1'b1;
                out_d.alucont      = ALU_ADD;
                out_d.pc_s         = PC_ALU;
                out_d.pcen         = 1'b1;
            end
            default: out_d = '0;
        endcase
    end

    always_comb begin
        fetch_out         = '0;
        fetch_out.irwrite = 1'b1;
        fetch_out.mem_s   = MEM_PC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            out_q   <= fetch_out;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Reset blanks every enable and select immediately, not just from the next edge
    assign out_gated = reset ? '0 : out_q;

    assign irwrite      = out_gated.irwrite;
    assign pcen         = out_gated.pcen;
    assign regwrite     = out_gated.regwrite;
    assign memwrite     = out_gated.memwrite;
    assign flag_we      = out_gated.flag_we;
    assign pc_s         = out_gated.pc_s;
    assign mem_s        = out_gated.mem_s;
    assign wd_s         = out_gated.wd_s;
    assign alua_s       = out_gated.alua_s;
    assign alub_s       = out_gated.alub_s;
    assign alucont      = out_gated.alucont;
    assign signext_sign = out_gated.signext_sign;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: per-cycle output vectors compared against an instruction-level model.
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic [2:0]  flags;
    logic        irwrite, pcen, regwrite, memwrite, flag_we, pc_s, mem_s, alua_s, signext_sign;
    logic [1:0]  wd_s, alub_s;
    logic [2:0]  alucont;
    logic [15:0] obs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ctrl_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .flags        (flags),
        .irwrite      (irwrite),
        .pcen         (pcen),
        .regwrite     (regwrite),
        .memwrite     (memwrite),
        .flag_we      (flag_we),
        .pc_s         (pc_s),
        .mem_s        (mem_s),
        .wd_s         (wd_s),
        .alua_s       (alua_s),
        .alub_s       (alub_s),
        .alucont      (alucont),
        .signext_sign (signext_sign)
    );

    assign obs = {irwrite, pcen, regwrite, memwrite, flag_we, pc_s, mem_s,
                  wd_s, alua_s, alub_s, alucont, signext_sign};

    // ---------------- reference model ----------------
    localparam int K_SKIP = 0, K_ALU_R = 1, K_ALU_I = 2, K_LOAD = 3,
                   K_STORE = 4, K_JUMP = 5, K_BRANCH = 6;

    function automatic logic [15:0] vec(input logic ir, pe, rw, mw, fw, pcs, ms,
                                        input logic [1:0] wd, input logic aa,
                                        input logic [1:0] ab, input logic [2:0] ac,
                                        input logic sx);
        return {ir, pe, rw, mw, fw, pcs, ms, wd, aa, ab, ac, sx};
    endfunction

    function automatic bit branch_build();
`ifdef CTRL_BRANCH_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit cond_ok(input int cc, input logic [2:0] f);
        bit c = f[2], z = f[1], n = f[0];
        if (cc == 0)  return z;
        if (cc == 1)  return !z;
        if (cc == 2)  return c;
        if (cc == 3)  return !c;
        if (cc == 6)  return n;
        if (cc == 7)  return !n;
        if (cc == 14) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit alu_known(input int code);
        return code == 1 || code == 2 || code == 3 || code == 5 ||
               code == 9 || code == 11 || code == 13;
    endfunction

    function automatic int kind_of(input logic [15:0] i, input logic [2:0] f);
        int op = int'(i[15:12]);
        int cc = int'(i[11:8]);
        int ex = int'(i[7:4]);
        if (op == 0)  return alu_known(ex) ? K_ALU_R : K_SKIP;
        if (op == 4) begin
            if (ex == 0) return K_LOAD;
            if (ex == 4) return K_STORE;
            if (ex == 12 && branch_build() && cond_ok(cc, f)) return K_JUMP;
            return K_SKIP;
        end
        if (op == 12) return (branch_build() && cond_ok(cc, f)) ? K_BRANCH : K_SKIP;
        return alu_known(op) ? K_ALU_I : K_SKIP;
    endfunction

    function automatic int exp_len(input logic [15:0] i, input logic [2:0] f);
        int k = kind_of(i, f);
        if (k == K_SKIP) return 2;
        if (k == K_LOAD) return 4;
        return 3;
    endfunction

    function automatic logic [15:0] exp_out(input logic [15:0] i, input logic [2:0] f, input int cyc);
        int k = kind_of(i, f);
        int code;
        bit imm, fw, rw, sx;
        logic [1:0] wd;
        logic [2:0] ac;
        if (cyc == 0) return vec(1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 3'd0, 0);
        if (cyc == 1) return vec(0, 1, 0, 0, 0, 1, 0, 2'b00, 1, 2'b10, 3'd0, 0);
        case (k)
            K_ALU_R, K_ALU_I: begin
                imm  = (k == K_ALU_I);
                code = imm ? int'(i[15:12]) : int'(i[7:4]);
                ac   = (code == 9 || code == 11) ? 3'd1 :
                       (code == 1) ? 3'd2 : (code == 2) ? 3'd3 :
                       (code == 3) ? 3'd4 : 3'd0;
                fw   = (code == 5 || code == 9 || code == 11);
                rw   = (code != 11);
                sx   = imm && fw;
                wd   = (code == 13) ? (imm ? 2'b00 : 2'b01) : 2'b11;
                return vec(0, 0, rw, 0, fw, 0, 0, wd, 0, imm ? 2'b01 : 2'b00, ac, sx);
            end
            K_LOAD:   return (cyc == 2) ? 16'h0000 : vec(0, 0, 1, 0, 0, 0, 0, 2'b10, 0, 2'b00, 3'd0, 0);
            K_STORE:  return vec(0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'd0, 0);
            K_JUMP:   return vec(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'd0, 0);
            K_BRANCH: return vec(0, 1, 0, 0, 0, 1, 0, 2'b00, 1, 2'b01, 3'd0, 1);
            default:  return 16'hxxxx;
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        instr = 16'h0000;
        flags = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_gated got=%h exp=%h", obs, 16'h0000);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== exp_out(16'h0000, 3'b000, 0)) begin
            errors++;
            $display("[TB] FAIL reset_first_fetch got=%h exp=%h", obs, exp_out(16'h0000, 3'b000, 0));
        end
    endtask

    task automatic test_alu();
        logic [15:0] list [6];
        list = '{16'h0152, 16'h53FF, 16'h13F0, 16'h0B12, 16'h0D34, 16'hD1A5};
        foreach (list[k]) begin
            instr = list[k];
            flags = 3'b000;
            for (int c = 0; c < exp_len(instr, flags); c++) begin
                checks++;
                if (obs !== exp_out(instr, flags, c)) begin
                    errors++;
                    $display("[TB] FAIL alu instr=%h cyc=%0d got=%h exp=%h", instr, c, obs, exp_out(instr, flags, c));
                end
                @(negedge clk); #1;
            end
        end
    endtask

    task automatic test_load_store();
        logic [15:0] list [3];
        list = '{16'h4405, 16'h4645, 16'h4405};
        foreach (list[k]) begin
            instr = list[k];
            flags = 3'b111;
            for (int c = 0; c < exp_len(instr, flags); c++) begin
                checks++;
                if (obs !== exp_out(instr, flags, c)) begin
                    errors++;
                    $display("[TB] FAIL ldst instr=%h cyc=%0d got=%h exp=%h", instr, c, obs, exp_out(instr, flags, c));
                end
                @(negedge clk); #1;
            end
        end
    endtask

    task automatic test_branch();
        logic [15:0] ilist [6];
        logic [2:0]  flist [6];
        ilist = '{16'hC0FE, 16'hC0FE, 16'h4EC3, 16'h41C3, 16'hC4FE, 16'hC7F0};
        flist = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000};
        foreach (ilist[k]) begin
            instr = ilist[k];
            flags = flist[k];
            for (int c = 0; c < exp_len(instr, flags); c++) begin
                checks++;
                if (obs !== exp_out(instr, flags, c)) begin
                    errors++;
                    $display("[TB] FAIL branch instr=%h flags=%b cyc=%0d got=%h exp=%h", instr, flags, c, obs, exp_out(instr, flags, c));
                end
                @(negedge clk); #1;
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] list [4];
        list = '{16'hF000, 16'h0F00, 16'h4010, 16'h7123};
        foreach (list[k]) begin
            instr = list[k];
            flags = 3'b010;
            for (int c = 0; c < exp_len(instr, flags); c++) begin
                checks++;
                if (obs !== exp_out(instr, flags, c)) begin
                    errors++;
                    $display("[TB] FAIL illegal instr=%h cyc=%0d got=%h exp=%h", instr, c, obs, exp_out(instr, flags, c));
                end
                @(negedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_load();
        instr = 16'h4405;
        flags = 3'b000;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs !== exp_out(instr, flags, c)) begin
                errors++;
                $display("[TB] FAIL midload_pre cyc=%0d got=%h exp=%h", c, obs, exp_out(instr, flags, c));
            end
            if (c < 2) begin
                @(negedge clk); #1;
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midload_gated got=%h exp=%h", obs, 16'h0000);
        end
        @(negedge clk); #1;
        checks++;
        if (regwrite !== 1'b0 || obs !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midload_held got=%h exp=%h", obs, 16'h0000);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== exp_out(instr, flags, 0)) begin
            errors++;
            $display("[TB] FAIL midload_refetch got=%h exp=%h", obs, exp_out(instr, flags, 0));
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [10];
        logic [3:0] exts [8];
        logic [3:0] op, ex;
        ops  = '{4'h0, 4'h0, 4'h4, 4'h4, 4'hC, 4'h1, 4'h5, 4'h9, 4'hB, 4'hD};
        exts = '{4'h5, 4'h9, 4'h1, 4'hB, 4'hD, 4'h0, 4'h4, 4'hC};
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom()) : ops[$urandom_range(0, 9)];
            ex = ($urandom_range(0, 4) == 0) ? 4'($urandom()) : exts[$urandom_range(0, 7)];
            instr = {op, 4'($urandom()), ex, 4'($urandom())};
            flags = 3'($urandom());
            for (int c = 0; c < exp_len(instr, flags); c++) begin
                checks++;
                if (obs !== exp_out(instr, flags, c)) begin
                    errors++;
                    $display("[TB] FAIL random instr=%h flags=%b cyc=%0d got=%h exp=%h", instr, flags, c, obs, exp_out(instr, flags, c));
                end
                @(negedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_illegal();
        test_reset_mid_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] run did not complete");
    end

endmodule
